alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Drives registered operands to an external combinational ALU, captures each
// result with a sequence tag into a small FIFO, and accumulates sticky status.
module alu_op_sequencer #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [Width-1:0] cmd_A,
    input  logic [Width-1:0] cmd_B,
    input  logic             cmd_Cin,
    input  logic [4:0]       cmd_F,
    output logic [Width-1:0] A,
    output logic [Width-1:0] B,
    output logic             Cin,
    output logic [4:0]       F,
    input  logic [Width-1:0] Out,
    input  logic [5:0]       Status,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [Width-1:0] res_Out,
    output logic [5:0]       res_Status,
    output logic [7:0]       res_tag,
    output logic [5:0]       sticky_Status,
    input  logic             clr_sticky
);

    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam int EW = Width + 6 + 8;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t             state_q, state_d;
    logic [Width-1:0]   a_q, a_d, b_q, b_d;
    logic               cin_q, cin_d;
    logic [4:0]         f_q, f_d;
    logic [7:0]         tag_q, tag_d, op_tag_q, op_tag_d;
    logic [CW-1:0]      count_q, count_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [5:0]         sticky_q, sticky_d;
    logic [EW-1:0]      mem_q [Depth];

    logic accept, push, pop;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        f_d       = f_q;
        tag_d     = tag_q;
        op_tag_d  = op_tag_q;
        cmd_ready = (state_q == IDLE) && !rst && (count_q < CW'(Depth));
        accept    = cmd_valid && cmd_ready;
        push      = (state_q == EXEC);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d      = cmd_A;
                    b_d      = cmd_B;
                    cin_d    = cmd_Cin;
                    f_d      = cmd_F;
                    op_tag_d = tag_q;
                    tag_d    = tag_q + 8'd1;
                    state_d  = EXEC;
                end
            end
            EXEC:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; pointers wrap naturally since Depth is a power of two
    always_comb begin
        pop      = res_valid && res_ready;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // A clear coinciding with a capture keeps only the fresh status
    always_comb begin
        sticky_d = sticky_q;
        if (push)
            sticky_d = clr_sticky ? Status : (sticky_q | Status);
        else if (clr_sticky)
            sticky_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            f_q      <= '0;
            tag_q    <= '0;
            op_tag_q <= '0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sticky_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            f_q      <= f_d;
            tag_q    <= tag_d;
            op_tag_q <= op_tag_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sticky_q <= sticky_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_q[wr_ptr_q] <= {Out, Status, op_tag_q};
    end

    assign A             = a_q;
    assign B             = b_q;
    assign Cin           = cin_q;
    assign F             = f_q;
    assign res_valid     = (count_q != '0);
    assign {res_Out, res_Status, res_tag} = mem_q[rd_ptr_q];
    assign sticky_Status = sticky_q;

endmodule
